mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the core's instruction-fetch
//  port (I) and data port (D). One transaction is outstanding at a time.
//  D has priority on conflict; a starvation counter guarantees I forward progress.
//  Sits between the mips core's imem/dmem buses and a unified RAM.
// PARAMETERS
//  AW          32  address width (byte address, passed through unmodified)
//  DW          32  data width
//  MEM_LAT     1   memory read latency: m_rdata valid MEM_LAT cycles after the m_en cycle; legal 1..15
//  STARVE_MAX  2   consecutive D grants allowed while I is pending; legal 1..15
// PORTS
//  clk      in   1   clock, rising edge
//  rst      in   1   asynchronous reset, active-low
//  i_req    in   1   fetch request, level; held until i_done
//  i_addr   in   AW  fetch address, stable while i_req
//  i_done   out  1   one-cycle pulse: fetch complete, i_rdata valid
//  i_rdata  out  DW  fetched word, registered, held until next I completion
//  d_req    in   1   data request, level; held until d_done
//  d_we     in   1   1 = write, 0 = read; stable while d_req
//  d_addr   in   AW  data address
//  d_wdata  in   DW  write data
//  d_done   out  1   one-cycle pulse: data access complete
//  d_rdata  out  DW  read word, registered, held until next D read completion
//  m_en     out  1   memory enable, one-cycle pulse per transaction, registered
//  m_we     out  1   memory write enable, qualified by m_en
//  m_addr   out  AW  memory address, registered
//  m_wdata  out  DW  memory write data, registered
//  m_rdata  in   DW  memory read data
//  busy     out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=0, any time, async): state=IDLE; every output 0, including i_rdata, d_rdata, m_*;
//   lat counter=0, starve counter=0. An in-flight transaction is dropped and no done pulse is issued.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   IDLE:  arbitrate the requests sampled this cycle; on a grant, register m_addr/m_we/m_wdata
//          and the owner (I/D); next state is ISSUE. With no request, stay in IDLE.
//   ISSUE: m_en=1 for exactly this cycle; lat_cnt loaded with MEM_LAT; next state is WAIT.
//   WAIT:  lat_cnt decrements each cycle. When lat_cnt==1, capture m_rdata into the owner's
//          rdata (reads only; writes leave rdata unchanged); next state is DONE.
//   DONE:  the owner's done pulse=1; next state is IDLE. Requests are not arbitrated in DONE.
//  Latency: req high in cycle 0 (IDLE) -> m_en in cycle 1 -> done in cycle MEM_LAT+2.
//   Writes use the same timing. Peak rate is one access per MEM_LAT+3 cycles.
//  Arbitration in IDLE:
//   Only I requests: grant I. Only D requests: grant D.
//   Both request: grant D unless starve_cnt==STARVE_MAX, in which case grant I.
//  starve_cnt:
//   Increments on a D grant while i_req=1, saturating at STARVE_MAX.
//   Clears on any I grant, and on a D grant while i_req=0.
//  Requester protocol:
//   req must drop in the cycle after done, or stay high to request again; IDLE re-arbitrates.
//   If req drops mid-transaction, the access still completes and done still pulses.
//   Address, data and we changes after the grant are ignored (values latched in IDLE).
//  m_we=0 whenever m_en=0. m_addr and m_wdata hold their last values between transactions.
//  I never writes: m_we=0 for every I transaction.
// TESTING
//  1. MEM_LAT=1, i_req@c0 with i_addr=0x40, memory returns 0xDEADBEEF -> m_en@c1 with m_addr=0x40;
//     i_done@c3 with i_rdata=0xDEADBEEF; busy high c1..c3.
//  2. Both req@c0 (d_we=0, d_addr=0x100) -> D served first, d_done@c3; I issued c5, i_done@c7.
//  3. STARVE_MAX=2, d_req held continuously, i_req held -> grant order D,D,I,D,D,I;
//     starve_cnt returns to 0 after each I grant.
//  4. Write then read: D writes 0x1234 to 0x8, then D reads 0x8 -> m_we=1 only in the write's m_en
//     cycle; d_rdata=0x1234 and is unchanged by the write completion.
//  5. rst asserted in WAIT -> all outputs 0 immediately; no done after release;
//     requests still pending are re-arbitrated from IDLE.
//  6. MEM_LAT=4, d_req dropped in cycle 2 -> d_done still pulses at cycle 6; no further grant.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous RAM between the fetch (I)
//               and data (D) ports, one transaction at a time, D-priority with
//               an I anti-starvation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] C_MEM_LAT    = 4'(MEM_LAT);
    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    state_t          state_q, state_d;
    logic [3:0]      lat_cnt_q, lat_cnt_d;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            owner_is_d_q, owner_is_d_d;
    logic            op_we_q, op_we_d;
    logic            m_en_q, m_en_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;
    logic            i_done_q, i_done_d;
    logic            d_done_q, d_done_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            w_grant_d;
    logic            w_grant_i;

    // D wins a conflict unless I has already waited STARVE_MAX D grants.
    assign w_grant_d = (state_q == ST_IDLE) && d_req &&
                       (!i_req || (starve_cnt_q != C_STARVE_MAX));
    assign w_grant_i = (state_q == ST_IDLE) && i_req && !w_grant_d;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        owner_is_d_d = owner_is_d_q;
        op_we_d      = op_we_q;
        m_en_d       = 1'b0;
        m_we_d       = 1'b0;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_d) begin
                    owner_is_d_d = 1'b1;
                    op_we_d      = d_we;
                    m_en_d       = 1'b1;
                    m_we_d       = d_we;
                    m_addr_d     = d_addr;
                    m_wdata_d    = d_wdata;
                    state_d      = ST_ISSUE;
                    if (!i_req) begin
                        starve_cnt_d = 4'd0;
                    end else if (starve_cnt_q != C_STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (w_grant_i) begin
                    owner_is_d_d = 1'b0;
                    op_we_d      = 1'b0;
                    m_en_d       = 1'b1;
                    m_addr_d     = i_addr;
                    starve_cnt_d = 4'd0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lat_cnt_d = C_MEM_LAT;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    // Done is registered here so it lines up with the DONE state.
                    if (owner_is_d_q) begin
                        d_done_d = 1'b1;
                        if (!op_we_q) d_rdata_d = m_rdata;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = m_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            lat_cnt_q    <= 4'd0;
            starve_cnt_q <= 4'd0;
            owner_is_d_q <= 1'b0;
            op_we_q      <= 1'b0;
            m_en_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            owner_is_d_q <= owner_is_d_d;
            op_we_q      <= op_we_d;
            m_en_q       <= m_en_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire
